// File: rtl/regfile_write_queue.sv
// Write queue and pending-write scoreboard in front of the 32x32 register bank.
// Define FWD_WRITE_EN to add fwdA_data/fwdB_data forwarding of the youngest pending write.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_sel,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  input  logic                       bank_stall,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_sel,
  output logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          selA,
  input  logic [ADDR_W-1:0]          selB,
  output logic                       busyA,
  output logic                       busyB,
`ifdef FWD_WRITE_EN
  output logic [DATA_W-1:0]          fwdA_data,
  output logic [DATA_W-1:0]          fwdB_data,
`endif
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, STALL} stateT;

  stateT             state, nextState;
  logic [ADDR_W-1:0] selMem  [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PW-1:0]     rdPtr, wrPtr;
  logic [LW-1:0]     lvl;
  logic              push, pop;

  assign in_ready = (lvl < LW'(DEPTH)) && !flush;
  // $zero requests complete the handshake but are dropped here
  assign push     = in_valid && in_ready && (in_sel != '0);
  assign level    = lvl;

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (lvl != '0) begin
          pop       = 1'b1;
          nextState = WRITE;
        end
      end
      WRITE, STALL: begin
        if (bank_stall) begin
          nextState = STALL;
        end else if (lvl != '0) begin
          pop       = 1'b1;
          nextState = WRITE;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (flush) begin
      nextState = IDLE;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      lvl     <= '0;
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      lvl   <= '0;
      wr_en <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr   <= rdPtr + 1'b1;
        wr_sel  <= selMem[rdPtr];
        wr_data <= dataMem[rdPtr];
      end
      lvl   <= lvl + LW'(push) - LW'(pop);
      wr_en <= (nextState != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      selMem[wrPtr]  <= in_sel;
      dataMem[wrPtr] <= in_data;
    end
  end

  function automatic logic pendHit(input logic [ADDR_W-1:0] s);
    logic          h;
    logic [PW-1:0] idx;
    h = wr_en && (wr_sel == s);
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PW'(k);
      if ((LW'(k) < lvl) && (selMem[idx] == s)) h = 1'b1;
    end
    return h && (s != '0);
  endfunction

  always_comb begin
    busyA = pendHit(selA);
    busyB = pendHit(selB);
  end

`ifdef FWD_WRITE_EN
  // Walk oldest to youngest so the last match wins
  function automatic logic [DATA_W-1:0] fwdLookup(input logic [ADDR_W-1:0] s);
    logic [DATA_W-1:0] d;
    logic [PW-1:0]     idx;
    d = '0;
    if (wr_en && (wr_sel == s)) d = wr_data;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PW'(k);
      if ((LW'(k) < lvl) && (selMem[idx] == s)) d = dataMem[idx];
    end
    return (s != '0) ? d : '0;
  endfunction

  always_comb begin
    fwdA_data = fwdLookup(selA);
    fwdB_data = fwdLookup(selB);
  end
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: vector table plus multi-cycle
// sequences for backpressure, flush and asynchronous reset.
module tb_regfile_write_queue;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_sel;
  logic [31:0] in_data;
  logic        flush, bank_stall;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic [31:0] wr_data;
  logic [4:0]  selA, selB;
  logic        busyA, busyB;
  logic [2:0]  level;
`ifdef FWD_WRITE_EN
  logic [31:0] fwdA_data, fwdB_data;
`endif

  int checks = 0;
  int errors = 0;

  regfile_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
    .flush(flush), .bank_stall(bank_stall),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .selA(selA), .selB(selB),
    .busyA(busyA), .busyB(busyB),
`ifdef FWD_WRITE_EN
    .fwdA_data(fwdA_data), .fwdB_data(fwdB_data),
`endif
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [4:0]  sel;
    logic [31:0] data;
    logic        stall;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic        eEn;
    logic [4:0]  eSel;
    logic [31:0] eData;
    logic        eBa;
    logic        eBb;
    logic [2:0]  eLvl;
    logic        eRdy;
  } vecT;

  vecT vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_sel     = '0;
    in_data    = '0;
    flush      = 1'b0;
    bank_stall = 1'b0;
    selA       = '0;
    selB       = '0;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] s, input logic [31:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    settle();
    nextCyc();
  endtask

  initial begin
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 5, 0,  0, 0, 0,            0, 0, 0, 1};
    vecs[1]  = '{0, 0, 0,            0, 5, 5,  0, 0, 0,            1, 1, 1, 1};
    vecs[2]  = '{0, 0, 0,            0, 5, 0,  1, 5, 32'hDEADBEEF, 1, 0, 0, 1};
    vecs[3]  = '{0, 0, 0,            0, 5, 0,  0, 0, 0,            0, 0, 0, 1};
    vecs[4]  = '{1, 0, 32'h1234,     0, 0, 0,  0, 0, 0,            0, 0, 0, 1};
    vecs[5]  = '{0, 0, 0,            0, 0, 0,  0, 0, 0,            0, 0, 0, 1};
    vecs[6]  = '{0, 0, 0,            0, 0, 0,  0, 0, 0,            0, 0, 0, 1};
    vecs[7]  = '{1, 8, 1,            0, 8, 5,  0, 0, 0,            0, 0, 0, 1};
    vecs[8]  = '{1, 8, 2,            0, 8, 5,  0, 0, 0,            1, 0, 1, 1};
    vecs[9]  = '{0, 0, 0,            1, 8, 5,  1, 8, 1,            1, 0, 1, 1};
    vecs[10] = '{0, 0, 0,            0, 8, 5,  1, 8, 1,            1, 0, 1, 1};
    vecs[11] = '{0, 0, 0,            0, 8, 5,  1, 8, 2,            1, 0, 0, 1};
    vecs[12] = '{0, 0, 0,            0, 8, 5,  0, 0, 0,            0, 0, 0, 1};

    rst = 1'b1;
    idle();
    selA = 5'd5;
    settle();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_level", level, 0);
    chk("rst_busyA", busyA, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nextCyc();

    for (int i = 0; i < 13; i++) begin
      in_valid   = vecs[i].vld;
      in_sel     = vecs[i].sel;
      in_data    = vecs[i].data;
      bank_stall = vecs[i].stall;
      selA       = vecs[i].sa;
      selB       = vecs[i].sb;
      flush      = 1'b0;
      settle();
      chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].eEn);
      chk($sformatf("vec%0d_level", i), level, vecs[i].eLvl);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].eRdy);
      chk($sformatf("vec%0d_busyA", i), busyA, vecs[i].eBa);
      chk($sformatf("vec%0d_busyB", i), busyB, vecs[i].eBb);
      if (vecs[i].eEn) begin
        chk($sformatf("vec%0d_wr_sel", i), wr_sel, vecs[i].eSel);
        chk($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].eData);
      end
`ifdef FWD_WRITE_EN
      if (i == 10) chk("vec10_fwdA", fwdA_data, 32'd2);
`endif
      nextCyc();
    end

    // fill with the bank stalled, then drain
    idle();
    bank_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_sel   = 5'(i);
      in_data  = 32'h100 + 32'(i);
      settle();
      chk($sformatf("fill%0d_in_ready", i), in_ready, 1);
      nextCyc();
    end
    idle();
    settle();
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);
    for (int j = 1; j <= 5; j++) begin
      chk($sformatf("drain%0d_wr_en", j), wr_en, 1);
      chk($sformatf("drain%0d_wr_sel", j), wr_sel, 32'(j));
      chk($sformatf("drain%0d_wr_data", j), wr_data, 32'h100 + 32'(j));
      nextCyc();
      settle();
    end
    chk("drain_done_wr_en", wr_en, 0);
    chk("drain_done_level", level, 0);
    nextCyc();

    // flush while one write is stalled and three are queued
    idle();
    bank_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(10 + i), 32'(i));
    in_valid   = 1'b1;
    in_sel     = 5'd20;
    in_data    = 32'h55;
    flush      = 1'b1;
    selA       = 5'd10;
    selB       = 5'd12;
    settle();
    chk("preflush_level", level, 3);
    chk("preflush_wr_en", wr_en, 1);
    chk("preflush_wr_sel", wr_sel, 10);
    chk("preflush_busyA", busyA, 1);
    chk("preflush_busyB", busyB, 1);
    chk("preflush_in_ready", in_ready, 0);
    nextCyc();
    idle();
    selA = 5'd10;
    selB = 5'd20;
    settle();
    chk("flush_level", level, 0);
    chk("flush_wr_en", wr_en, 0);
    chk("flush_busyA", busyA, 0);
    chk("flush_busyB", busyB, 0);
    chk("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      nextCyc();
      settle();
      chk($sformatf("postflush%0d_wr_en", i), wr_en, 0);
    end
    nextCyc();

    // asynchronous reset while writing with two entries queued
    idle();
    bank_stall = 1'b1;
    for (int i = 1; i <= 3; i++) push(5'(i), 32'(i));
    in_valid = 1'b0;
    selA     = 5'd1;
    selB     = 5'd3;
    settle();
    chk("prerst_wr_en", wr_en, 1);
    chk("prerst_level", level, 2);
    chk("prerst_busyA", busyA, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_level", level, 0);
    chk("arst_wr_sel", wr_sel, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_busyA", busyA, 0);
    chk("arst_busyB", busyB, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bank_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCyc();
      settle();
      chk($sformatf("postrst%0d_wr_en", i), wr_en, 0);
      chk($sformatf("postrst%0d_in_ready", i), in_ready, 1);
      chk($sformatf("postrst%0d_level", i), level, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
